// File: rtl/regfile_writeback.sv
// Writeback stage: round-robin arbitration between ALU and LSU results, a registered
// register-file write port, and a pending-write scoreboard that stalls decode on hazards.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    output logic [ADDR_WIDTH-1:0]        write_addr1,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic                         write_enable,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic [ADDR_WIDTH-1:0]        read_addr1,
    input  logic [ADDR_WIDTH-1:0]        read_addr2,
    output logic                         stall,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending
);

    logic                         last_grant_q, last_grant_d;
    logic                         write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0]        write_addr1_q, write_addr1_d;
    logic [DATA_WIDTH-1:0]        write_data_q, write_data_d;
    logic [(1<<ADDR_WIDTH)-1:0]   pending_q, pending_d;
    logic                         alu_xfer, lsu_xfer;

    // last_grant_q = 1 means the LSU won last, so the ALU takes the next tie
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!reset) begin
            if (alu_valid && (!lsu_valid || last_grant_q)) begin
                alu_ready = 1'b1;
            end else if (lsu_valid) begin
                lsu_ready = 1'b1;
            end
        end
    end

    assign alu_xfer = alu_valid & alu_ready;
    assign lsu_xfer = lsu_valid & lsu_ready;

    always_comb begin
        last_grant_d   = last_grant_q;
        write_enable_d = 1'b0;
        write_addr1_d  = write_addr1_q;
        write_data_d   = write_data_q;
        if (alu_xfer) begin
            last_grant_d = 1'b0;
            if (alu_rd != '0) begin
                write_enable_d = 1'b1;
                write_addr1_d  = alu_rd;
                write_data_d   = alu_data;
            end
        end else if (lsu_xfer) begin
            last_grant_d = 1'b1;
            if (lsu_rd != '0) begin
                write_enable_d = 1'b1;
                write_addr1_d  = lsu_rd;
                write_data_d   = lsu_data;
            end
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = pending_q[read_addr1] | pending_q[read_addr2]
                  | (issue_valid & pending_q[issue_rd]);
        end
    end

    // Clear is applied before set so a same-edge issue keeps the bit pending
    always_comb begin
        pending_d = pending_q;
        if (write_enable_q) begin
            pending_d[write_addr1_q] = 1'b0;
        end
        if (issue_valid && !stall && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            write_enable_q <= 1'b0;
            write_addr1_q  <= '0;
            write_data_q   <= '0;
            pending_q      <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            write_enable_q <= write_enable_d;
            write_addr1_q  <= write_addr1_d;
            write_data_q   <= write_data_d;
            pending_q      <= pending_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr1  = write_addr1_q;
    assign write_data   = write_data_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all checked
// against an abstract model of arbitration, write stage and scoreboard.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic [4:0]  write_addr1;
    logic [31:0] write_data;
    logic        write_enable;
    logic        issue_valid;
    logic [4:0]  issue_rd, read_addr1, read_addr2;
    logic        stall;
    logic [31:0] pending;

    int errors = 0;
    int checks = 0;

    // Abstract model state
    bit          m_pend [32];
    bit          m_prefer_alu;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          exp_alu_ready, exp_lsu_ready, exp_stall;

    // Behavioural register file fed from the DUT write port
    logic [31:0] rf [32];

    regfile_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .write_addr1(write_addr1), .write_data(write_data), .write_enable(write_enable),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) rf[write_addr1] <= write_data;
    end

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: check combinational outputs, advance the model, check registers
    task automatic applyStimulus();
        bit          clr_we;
        logic [4:0]  clr_addr;
        #1;
        if (reset) begin
            exp_alu_ready = 0;
            exp_lsu_ready = 0;
            exp_stall     = 0;
        end else begin
            exp_stall = m_pend[read_addr1] || m_pend[read_addr2] || (issue_valid && m_pend[issue_rd]);
            if (alu_valid && lsu_valid) begin
                exp_alu_ready = m_prefer_alu;
                exp_lsu_ready = !m_prefer_alu;
            end else begin
                exp_alu_ready = alu_valid;
                exp_lsu_ready = lsu_valid;
            end
        end
        checkOutput("alu_ready", alu_ready, exp_alu_ready);
        checkOutput("lsu_ready", lsu_ready, exp_lsu_ready);
        checkOutput("stall", stall, exp_stall);

        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_prefer_alu = 1;
            m_we   = 0;
            m_addr = 0;
            m_data = 0;
        end else begin
            clr_we   = m_we;
            clr_addr = m_addr;
            m_we = 0;
            if (exp_alu_ready) begin
                m_prefer_alu = 0;
                if (alu_rd != 0) begin m_we = 1; m_addr = alu_rd; m_data = alu_data; end
            end
            if (exp_lsu_ready) begin
                m_prefer_alu = 1;
                if (lsu_rd != 0) begin m_we = 1; m_addr = lsu_rd; m_data = lsu_data; end
            end
            if (clr_we) m_pend[clr_addr] = 0;
            if (issue_valid && !exp_stall && issue_rd != 0) m_pend[issue_rd] = 1;
        end

        @(posedge clk);
        #1;
        checkOutput("write_enable", write_enable, m_we);
        checkOutput("write_addr1", write_addr1, m_addr);
        checkOutput("write_data", write_data, m_data);
        checkOutput("pending", pending, model_pending());
    endtask

    task automatic idleInputs();
        alu_valid = 0; lsu_valid = 0; issue_valid = 0;
        alu_rd = 0; lsu_rd = 0; alu_data = 0; lsu_data = 0;
        issue_rd = 0; read_addr1 = 0; read_addr2 = 0;
    endtask

    initial begin
        int rr_seq [4];
        int ai, li;
        rr_seq = '{2, 4, 3, 5};
        foreach (rf[i]) rf[i] = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_prefer_alu = 1; m_we = 0; m_addr = 0; m_data = 0;
        idleInputs();
        reset = 1;
        @(posedge clk);
        #1;

        // Reset with valids asserted: readies must stay low
        alu_valid = 1; alu_rd = 3; lsu_valid = 1; lsu_rd = 4;
        applyStimulus();
        applyStimulus();
        reset = 0;
        idleInputs();
        applyStimulus();
        checkOutput("idle_we", write_enable, 0);
        checkOutput("idle_pending", pending, 0);

        // Issue x1, RAW stall, ALU writeback, release
        issue_valid = 1; issue_rd = 1;
        applyStimulus();
        issue_valid = 0; read_addr1 = 1;
        #1 checkOutput("raw_stall", stall, 1);
        alu_valid = 1; alu_rd = 1; alu_data = 32'hAF;
        applyStimulus();
        checkOutput("wb_we", write_enable, 1);
        checkOutput("wb_addr", write_addr1, 1);
        checkOutput("wb_data", write_data, 32'hAF);
        alu_valid = 0;
        applyStimulus();
        checkOutput("raw_release", stall, 0);
        checkOutput("rf_x1", rf_read(5'd1), 32'hAF);

        // Round-robin after reset: ALU wins first tie
        reset = 1;
        applyStimulus();
        reset = 0;
        idleInputs();
        ai = 0; li = 0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = (ai < 2); alu_rd = (ai == 0) ? 5'd2 : 5'd3; alu_data = 32'h100 + ai;
            lsu_valid = (li < 2); lsu_rd = (li == 0) ? 5'd4 : 5'd5; lsu_data = 32'h200 + li;
            applyStimulus();
            checkOutput("rr_we", write_enable, 1);
            checkOutput("rr_addr", write_addr1, rr_seq[k]);
            ai += int'(exp_alu_ready);
            li += int'(exp_lsu_ready);
        end
        idleInputs();

        // x0: acknowledged but dropped; issue to x0 leaves scoreboard alone
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hAA;
        applyStimulus();
        checkOutput("x0_we", write_enable, 0);
        checkOutput("x0_read", rf_read(5'd0), 0);
        lsu_valid = 0; issue_valid = 1; issue_rd = 0;
        applyStimulus();
        checkOutput("x0_pending", pending, 0);

        // WAW stall, then same-edge set and clear on x6
        issue_rd = 6;
        applyStimulus();
        #1 checkOutput("waw_stall", stall, 1);
        applyStimulus();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
        applyStimulus();
        alu_valid = 0;
        applyStimulus();
        checkOutput("x6_cleared", pending[6], 0);
        alu_valid = 1; alu_data = 32'h77;
        applyStimulus();
        alu_valid = 0; issue_valid = 1; issue_rd = 6;
        applyStimulus();
        checkOutput("set_wins", pending[6], 1);
        checkOutput("rf_x6", rf_read(5'd6), 32'h77);
        idleInputs();

        // Reset coinciding with an ALU result
        issue_valid = 1; issue_rd = 7;
        applyStimulus();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7;
        reset = 1;
        applyStimulus();
        reset = 0;
        alu_valid = 0;
        applyStimulus();
        checkOutput("rst_no_we", write_enable, 0);
        checkOutput("rst_pend7", pending[7], 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 63) == 0);
            alu_valid   = $urandom_range(0, 1);
            lsu_valid   = $urandom_range(0, 1);
            alu_rd      = 5'($urandom_range(0, 31));
            lsu_rd      = 5'($urandom_range(0, 31));
            alu_data    = $urandom;
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            read_addr1  = 5'($urandom_range(0, 31));
            read_addr2  = 5'($urandom_range(0, 31));
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
